// File: rtl/led_pkg.sv
// Shared types and constants for the LED blink scheduler.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } led_state_e;

  localparam int TICK_W = 25;
  localparam int CNT_W  = 4;

  // 50 MHz clock, 1 Hz blink: 25e6 cycles per half-period.
  localparam logic [TICK_W-1:0] TICK_MAX_DEF = 25'd24_999_999;

endpackage

// File: rtl/led_tick_gen.sv
// Half-period counter: counts 0..TICK_MAX and flags tick at TICK_MAX.
// A synchronous clear restarts the count so each phase lasts exactly TICK_MAX+1 cycles.
module led_tick_gen
  import led_pkg::*;
#(
  parameter logic [TICK_W-1:0] TICK_MAX = TICK_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  logic [TICK_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + TICK_W'(1);
    if (clr_i || (cnt_q == TICK_MAX)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == TICK_MAX);

endmodule

// File: rtl/led_blink_sched.sv
// Round-robin owner of one LED: grants a requester, plays its 0-15 blink burst, then re-arbitrates.
// Grant one cycle after req; `LED_BLINK_GAP_EN adds GAP_HP dark half-periods after every burst.
module led_blink_sched
  import led_pkg::*;
#(
  parameter int                N_REQ    = 4,
  parameter logic [TICK_W-1:0] TICK_MAX = TICK_MAX_DEF,
  parameter int                GAP_HP   = 2
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [CNT_W*N_REQ-1:0] blinks,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   led_out
);

  localparam int             IW     = $clog2(N_REQ);
  localparam logic [IW:0]    NREQ_W = (IW+1)'(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || GAP_HP < 1 || GAP_HP > 15) begin : g_param_err
    $error("led_blink_sched: N_REQ or GAP_HP out of range");
  end

`ifdef LED_BLINK_GAP_EN
  localparam led_state_e POST_ST = GAP;
`else
  localparam led_state_e POST_ST = IDLE;
`endif

  led_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d, own_q, own_d, sel;
  logic             sel_vld;
  logic [CNT_W-1:0] cnt_q, cnt_d, sel_blinks;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic             busy_q, busy_d, led_q, led_d;
  logic             tick, tick_clr, grant, finish;
  logic [CNT_W-1:0] blinks_a [N_REQ];

`ifdef LED_BLINK_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_HP - 1);
  logic [CNT_W-1:0] gap_q, gap_d;
`endif

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign blinks_a[gi] = blinks[CNT_W*gi +: CNT_W];
  end

  // First set request at or above the pointer, wrapping at N_REQ.
  always_comb begin
    logic [IW:0] cand;
    cand    = '0;
    sel_vld = 1'b0;
    sel     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!sel_vld && req[cand[IW-1:0]]) begin
        sel_vld = 1'b1;
        sel     = cand[IW-1:0];
      end
    end
  end

  assign sel_blinks = blinks_a[sel];
  assign grant      = (state_q == IDLE) && sel_vld;
  // A zero-count grant parks in OFF for one cycle so done trails gnt by exactly one cycle.
  assign finish     = (state_q == OFF) &&
                      ((cnt_q == '0) || (tick && (cnt_q == CNT_W'(1))));

  led_tick_gen #(
    .TICK_MAX (TICK_MAX)
  ) u_tick (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  assign tick_clr = (state_d != state_q);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = (sel_blinks == '0) ? OFF : ON;
        end
      end
      ON: begin
        if (tick) begin
          state_d = OFF;
        end
      end
      OFF: begin
        if (finish) begin
          state_d = POST_ST;
        end else if (tick) begin
          state_d = ON;
        end
      end
      GAP: begin
`ifdef LED_BLINK_GAP_EN
        if (tick && (gap_q == GAP_LAST)) begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // busy also covers the first IDLE cycle, so it brackets the done pulse or the whole gap.
  always_comb begin
    gnt_d  = '0;
    done_d = '0;
    if (grant) begin
      gnt_d[sel] = 1'b1;
    end
    if (finish) begin
      done_d[own_q] = 1'b1;
    end
    busy_d = (state_q != IDLE) || (state_d != IDLE);
    led_d  = (state_d == ON);
  end

  always_comb begin
    ptr_d = ptr_q;
    own_d = own_q;
    cnt_d = cnt_q;
    if (grant) begin
      ptr_d = (sel == IW'(N_REQ - 1)) ? '0 : sel + IW'(1);
      own_d = sel;
      cnt_d = sel_blinks;
    end else if ((state_q == OFF) && tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

`ifdef LED_BLINK_GAP_EN
  always_comb begin
    gap_d = '0;
    if ((state_q == GAP) && (state_d == GAP)) begin
      gap_d = tick ? gap_q + CNT_W'(1) : gap_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ptr_q  <= '0;
      own_q  <= '0;
      cnt_q  <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
      led_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      own_q  <= own_d;
      cnt_q  <= cnt_d;
      gnt_q  <= gnt_d;
      done_q <= done_d;
      busy_q <= busy_d;
      led_q  <= led_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_led_blink_sched.sv
// Bench for led_blink_sched: directed and random request episodes against a burst-level timeline model.
module tb_led_blink_sched;

  localparam int N      = 4;
  localparam int HP     = 4;
  localparam int GAP_HP = 2;
`ifdef LED_BLINK_GAP_EN
  localparam int GC = GAP_HP * HP;
`else
  localparam int GC = 0;
`endif
  localparam int MAXL = 1024;

  logic           sys_clk   = 1'b0;
  logic           sys_rst_n = 1'b0;
  logic [N-1:0]   req       = '0;
  logic [4*N-1:0] blinks    = '0;
  logic [N-1:0]   gnt, done;
  logic           busy, led_out;

  int n_asrt = 0;
  int n_fail = 0;
  int ptr_m  = 0;
  int ep     = 0;
  logic [9:0] expv [MAXL];

  led_blink_sched #(
    .N_REQ    (N),
    .TICK_MAX (25'd3),
    .GAP_HP   (GAP_HP)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .blinks    (blinks),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .led_out   (led_out)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s ep%0d[%0d] observed=%h expected=%h", tag, ep, idx, obs, exp);
    end
  endtask

  // Expected vector per cycle: {gnt[3:0], done[3:0], busy, led}.
  task automatic run_ep(input logic [N-1:0] mask, input logic [4*N-1:0] blv,
                        input bit hold, input int k_max, input int drop_dly);
    int t, g, d, b, i, ng, len;
    logic [N-1:0] s;
    int rel [N];
    for (int x = 0; x < MAXL; x++) expv[x] = '0;
    s  = mask;
    t  = 1;
    ng = 0;
    while (s != '0 && ng < k_max) begin
      i = -1;
      for (int k = 0; k < N; k++)
        if (i < 0 && s[(ptr_m + k) % N]) i = (ptr_m + k) % N;
      b = int'(blv[4*i +: 4]);
      g = t;
      d = (b == 0) ? g + 1 : g + 2 * b * HP;
      expv[g][6+i] = 1'b1;
      expv[d][2+i] = 1'b1;
      for (int c = g; c <= d + GC; c++) expv[c][1] = 1'b1;
      for (int p = 0; p < b; p++)
        for (int c = 0; c < HP; c++) expv[g + 2*p*HP + c][0] = 1'b1;
      if (!hold) s[i] = 1'b0;
      ptr_m = (i + 1) % N;
      ng++;
      t = d + GC + 1;
    end
    len = t + 2;
    for (int k = 0; k < N; k++) rel[k] = -1;
    blinks = blv;
    req    = mask;
    ng     = 0;
    for (int off = 1; off <= len; off++) begin
      @(negedge sys_clk);
      check("cycle", off, {gnt, done, busy, led_out}, expv[off]);
      if (gnt != '0) begin
        ng++;
        if (hold) begin
          if (ng >= k_max) req = '0;
        end else begin
          for (int k = 0; k < N; k++)
            if (gnt[k]) begin
              rel[k] = off + drop_dly;
              blinks[4*k +: 4] = 4'($urandom_range(0, 15));
            end
        end
      end
      for (int k = 0; k < N; k++)
        if (rel[k] == off) req[k] = 1'b0;
    end
    req = '0;
    ep++;
  endtask

  initial begin
    logic [N-1:0]   m;
    logic [4*N-1:0] bv;
    bit             h;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("reset_outputs", 0, {gnt, done, busy, led_out}, 10'd0);

    // Abandon a burst with reset while the LED is lit.
    sys_rst_n = 1'b1;
    req       = 4'b0010;
    blinks    = 16'h0030;
    @(negedge sys_clk);
    check("pre_rst_gnt", 0, gnt, 4'b0010);
    check("pre_rst_led", 0, led_out, 1'b1);
    check("pre_rst_busy", 0, busy, 1'b1);
    req = '0;
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1 check("async_rst", 0, {gnt, done, busy, led_out}, 10'd0);
    @(negedge sys_clk);
    check("held_rst", 0, {gnt, done, busy, led_out}, 10'd0);
    sys_rst_n = 1'b1;
    ptr_m     = 0;

    run_ep(4'b0100, 16'h0100, 1'b0, 99, 0);  // first grant after reset
    run_ep(4'b1000, 16'h0000, 1'b0, 99, 0);  // zero count
    run_ep(4'b1111, 16'h1111, 1'b1, 5, 0);   // held requests rotate 0,1,2,3,0
    run_ep(4'b0010, 16'h0030, 1'b0, 99, 0);  // three-blink burst
    run_ep(4'b0001, 16'h0002, 1'b0, 99, 2);  // req dropped mid-burst

    for (int r = 0; r < 16; r++) begin
      m = 4'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) bv[4*k +: 4] = 4'($urandom_range(0, 3));
      h = ($urandom_range(0, 3) == 0);
      run_ep(m, bv, h, h ? $countones(m) + int'($urandom_range(0, 3)) : 99,
             int'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
